// File: rtl/premuat_n.sv
// rtl/premuat_n.sv - registered even/odd lane permutation with 2-entry skid buffer
module premuat_n #(
    parameter int WIDTH = 28,
    parameter int MAXN  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [MAXN*WIDTH-1:0]   i_data,
    input  logic [1:0]              i_size,
    input  logic                    i_inverse,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [MAXN*WIDTH-1:0]   o_data,
    output logic [1:0]              o_size,
    output logic                    o_inverse
);

    localparam int DW = MAXN * WIDTH;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } state_t;

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [1:0]      out_size_q, out_size_d;
    logic            out_inv_q, out_inv_d;
    logic [DW-1:0]   skid_data_q, skid_data_d;
    logic [1:0]      skid_size_q, skid_size_d;
    logic            skid_inv_q, skid_inv_d;
    logic [DW-1:0]   perm_data;
    logic            accept;
    logic            consume;
    int              perm_n;

    // Lanes at or above the active size keep their position.
    always_comb begin
        perm_n = 4 << i_size;
        if (perm_n > MAXN) begin
            perm_n = MAXN;
        end
        perm_data = i_data;
        for (int k = 0; k < MAXN / 2; k++) begin
            if (k < perm_n / 2) begin
                if (!i_inverse) begin
                    perm_data[k*WIDTH +: WIDTH]              = i_data[(2*k)*WIDTH +: WIDTH];
                    perm_data[(perm_n/2 + k)*WIDTH +: WIDTH] = i_data[(2*k+1)*WIDTH +: WIDTH];
                end else begin
                    perm_data[(2*k)*WIDTH +: WIDTH]   = i_data[k*WIDTH +: WIDTH];
                    perm_data[(2*k+1)*WIDTH +: WIDTH] = i_data[(perm_n/2 + k)*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_size_d  = out_size_q;
        out_inv_d   = out_inv_q;
        skid_data_d = skid_data_q;
        skid_size_d = skid_size_q;
        skid_inv_d  = skid_inv_q;
        accept      = i_valid & ready_q;
        consume     = (state_q != S_EMPTY) & i_ready;

        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    out_data_d = perm_data;
                    out_size_d = i_size;
                    out_inv_d  = i_inverse;
                    state_d    = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && consume) begin
                    out_data_d = perm_data;
                    out_size_d = i_size;
                    out_inv_d  = i_inverse;
                end else if (accept) begin
                    skid_data_d = perm_data;
                    skid_size_d = i_size;
                    skid_inv_d  = i_inverse;
                    state_d     = S_FULL;
                end else if (consume) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                // ready_q is low here, so only draining is possible.
                if (consume) begin
                    out_data_d = skid_data_q;
                    out_size_d = skid_size_q;
                    out_inv_d  = skid_inv_q;
                    state_d    = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        ready_d = (state_d != S_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            ready_q     <= 1'b0;
            out_data_q  <= '0;
            out_size_q  <= '0;
            out_inv_q   <= 1'b0;
            skid_data_q <= '0;
            skid_size_q <= '0;
            skid_inv_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            out_data_q  <= out_data_d;
            out_size_q  <= out_size_d;
            out_inv_q   <= out_inv_d;
            skid_data_q <= skid_data_d;
            skid_size_q <= skid_size_d;
            skid_inv_q  <= skid_inv_d;
        end
    end

    assign o_valid   = (state_q != S_EMPTY);
    assign o_ready   = ready_q;
    assign o_data    = out_data_q;
    assign o_size    = out_size_q;
    assign o_inverse = out_inv_q;

endmodule

// File: tb/tb_premuat_n.sv
// tb/tb_premuat_n.sv - scoreboard bench for premuat_n
module tb_premuat_n;

    localparam int W  = 28;
    localparam int M  = 32;
    localparam int DW = W * M;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic [1:0]    sz;
        logic          inv;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b0;
    logic          i_inverse = 1'b0;
    logic [1:0]    i_size = 2'd0;
    logic [DW-1:0] i_data = '0;
    logic          o_ready, o_valid, o_inverse;
    logic [1:0]    o_size;
    logic [DW-1:0] o_data;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    n_acc   = 0;
    beat_t exp_q[$];
    int    pop_cyc[$];

    premuat_n #(.WIDTH(W), .MAXN(M)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_size(i_size), .i_inverse(i_inverse),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_size(o_size), .o_inverse(o_inverse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference from the defining formulas, written per output lane.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [1:0] s, input logic inv);
        int n;
        logic [DW-1:0] r;
        n = 4 << s;
        if (n > M) n = M;
        r = d;
        for (int j = 0; j < n; j++) begin
            int src;
            if (!inv) src = (j < n/2) ? 2*j : 2*(j - n/2) + 1;
            else      src = (j % 2 == 0) ? j/2 : n/2 + j/2;
            r[j*W +: W] = d[src*W +: W];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        logic [31:0]   v;
        for (int k = 0; k < M; k++) begin
            v = $urandom();
            r[k*W +: W] = v[W-1:0];
        end
        return r;
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic [1:0] s, input logic inv, input logic [DW-1:0] e);
        logic rdy;
        int   t;
        beat_t b;
        t = 0;
        i_valid = 1'b1;
        i_data = d;
        i_size = s;
        i_inverse = inv;
        do begin
            rdy = o_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!rdy && t < 200);
        if (!rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got o_ready=0 expected acceptance within 200 cycles");
        end else begin
            b.dat = e;
            b.sz  = s;
            b.inv = inv;
            exp_q.push_back(b);
            n_acc++;
        end
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_pending", DW'(exp_q.size()), '0);
    endtask

    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got %h expected none", o_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("out_data", o_data, e.dat);
                check("out_size", DW'(o_size), DW'(e.sz));
                check("out_inverse", DW'(o_inverse), DW'(e.inv));
                pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        logic [DW-1:0] x, y, e, a;
        logic [DW-1:0] bp[4];
        int            t8[8];
        int            sg[4];
        int            t;
        logic [1:0]    msz[4];
        t8  = '{0, 2, 4, 6, 1, 3, 5, 7};
        sg  = '{-1, -134217728, 5, 134217727};
        msz = '{2'd0, 2'd3, 2'd1, 2'd2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_o_valid", DW'(o_valid), '0);
        check("rst_o_ready", DW'(o_ready), '0);
        check("rst_o_data", o_data, '0);
        check("rst_o_size_inv", DW'({o_size, o_inverse}), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("o_ready_before_rise", DW'(o_ready), '0);
        @(negedge clk);
        check("o_ready_after_rst", DW'(o_ready), DW'(1));
        @(posedge clk); #1;

        // Forward N=8 on lane index values.
        i_ready = 1'b1;
        for (int k = 0; k < M; k++) begin
            x[k*W +: W] = W'(k);
            e[k*W +: W] = (k < 8) ? W'(t8[k]) : W'(k);
        end
        send(x, 2'd1, 1'b0, e);
        @(negedge clk);
        check("latency_o_valid", DW'(o_valid), DW'(1));
        drain();

        // Inverse N=32 on lane index values.
        for (int k = 0; k < M/2; k++) begin
            e[(2*k)*W +: W]   = W'(k);
            e[(2*k+1)*W +: W] = W'(16 + k);
        end
        send(x, 2'd3, 1'b1, e);
        drain();

        // Forward then inverse returns the original at every size.
        for (int s = 0; s < 4; s++) begin
            x = rand_beat();
            y = model(x, 2'(s), 1'b0);
            send(x, 2'(s), 1'b0, y);
            send(y, 2'(s), 1'b1, x);
        end
        drain();

        // Sign extremes at N=4.
        x = '0;
        e = '0;
        x[0*W +: W] = W'(-1);
        x[1*W +: W] = W'(5);
        x[2*W +: W] = W'(-134217728);
        x[3*W +: W] = W'(134217727);
        for (int k = 0; k < 4; k++) e[k*W +: W] = sg[k][W-1:0];
        for (int k = 4; k < M; k++) begin
            x[k*W +: W] = W'(k * 1000);
            e[k*W +: W] = W'(k * 1000);
        end
        send(x, 2'd0, 1'b0, e);
        drain();

        // Backpressure: A held, B into skid, C waits.
        i_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 4; i++) bp[i] = rand_beat();
        a = model(bp[0], 2'd2, 1'b0);
        fork
            begin
                for (int i = 0; i < 4; i++) send(bp[i], 2'd2, 1'b0, model(bp[i], 2'd2, 1'b0));
            end
            begin
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!o_valid && t < 50);
                check("bp_a_appears", DW'(o_valid), DW'(1));
                check("bp_a_data", o_data, a);
                @(negedge clk);
                check("bp_a_held1", o_data, a);
                check("bp_ready_low1", DW'(o_ready), '0);
                check("bp_accepted_two", DW'(n_acc), DW'(2));
                @(negedge clk);
                check("bp_a_held2", o_data, a);
                check("bp_ready_low2", DW'(o_ready), '0);
                check("bp_c_waits", DW'(n_acc), DW'(2));
                @(posedge clk); #1;
                i_ready = 1'b1;
            end
        join
        drain();

        // Mixed sizes back to back, alternating mode, no bubbles.
        pop_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            x = rand_beat();
            send(x, msz[i], 1'(i % 2), model(x, msz[i], 1'(i % 2)));
        end
        drain();
        check("mixed_no_bubble", DW'(pop_cyc[3] - pop_cyc[0]), DW'(3));

        // Reset while FULL discards held beats.
        i_ready = 1'b0;
        x = rand_beat();
        send(x, 2'd3, 1'b0, model(x, 2'd3, 1'b0));
        y = rand_beat();
        send(y, 2'd1, 1'b1, model(y, 2'd1, 1'b1));
        check("full_ready_low", DW'(o_ready), '0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_o_valid", DW'(o_valid), '0);
        check("mid_rst_o_ready", DW'(o_ready), '0);
        check("mid_rst_o_data", o_data, '0);
        @(negedge clk);
        check("mid_rst_ready_rise", DW'(o_ready), DW'(1));
        @(posedge clk); #1;
        i_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_idle", DW'(o_valid), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/premuat_n.md
# premuat_n

Registered, parametrised even/odd lane permutation for the transform partial-butterfly datapath.
- Reorders up to MAXN coefficient lanes per beat for a runtime-selected transform size of 4/8/16/32 points.
- Forward mode gathers even-indexed lanes, then odd-indexed lanes; inverse mode interleaves them back.
- Sits between the transpose memory and the butterfly stages. It replaces the fixed per-size combinational permutation blocks with one pipelined, valid/ready-handshaked stage that has a 2-entry skid buffer.

## Interface
- WIDTH, 28, signed bits per coefficient lane.
- MAXN, 32, number of lanes; legal values 4, 8, 16, 32.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream beat present.
- o_ready  output  1  block can accept a beat; registered.
- i_data  input  MAXN*WIDTH  lane k at bits [k*WIDTH +: WIDTH].
- i_size  input  2  transform size: 00=4, 01=8, 10=16, 11=32.
- i_inverse  input  1  0=forward (even/odd split), 1=inverse (interleave).
- o_valid  output  1  output beat present.
- i_ready  input  1  downstream accepts the output beat.
- o_data  output  MAXN*WIDTH  permuted lanes.
- o_size  output  2  i_size carried with the beat.
- o_inverse  output  1  i_inverse carried with the beat.

## Operation
- N = 4 << i_size, clamped to MAXN if larger. N, i_size and i_inverse are sampled with each accepted beat.
- Forward mode, for k < N/2:
  - o[k] = i[2k]
  - o[N/2+k] = i[2k+1]
- Inverse mode, for k < N/2:
  - o[2k] = i[k]
  - o[2k+1] = i[N/2+k]
- Lanes N..MAXN-1 pass through unchanged.
- Lanes are moved bit-exact. There is no arithmetic, so sign is preserved.
- Forward then inverse at the same size is the identity.
- For N=4 both modes give lane order 0,2,1,3.
- Storage: output register (OUT) plus one skid register (SKID), each holding data, size, inverse and a valid flag.
- Occupancy states:
  - EMPTY: OUT invalid, SKID invalid.
  - ONE: OUT valid, SKID invalid.
  - FULL: OUT valid, SKID valid.
- Definitions: accept = i_valid & o_ready; consume = o_valid & i_ready.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept, no consume → FULL; the new beat goes to SKID.
  - ONE + accept + consume → ONE; the new beat replaces OUT.
  - ONE + consume, no accept → EMPTY.
  - FULL + consume → ONE; SKID moves to OUT.
  - No accept is possible in FULL.
- The permutation is applied when a beat enters OUT or SKID. SKID therefore holds already-permuted data.
- o_ready is registered as (next state != FULL). It is never combinationally dependent on i_ready.
- Output stability: while o_valid=1 and i_ready=0, o_data, o_size and o_inverse hold constant.
- Ordering: beats leave in acceptance order. None are dropped or duplicated.
- When rst=1:
  - All state is cleared to EMPTY regardless of handshakes.
  - Any beats in flight are discarded.
  - i_valid is ignored.

## Timing
- Reset values, present the cycle after rst is sampled high:
  - o_valid=0, o_ready=0.
  - o_data=0, o_size=0, o_inverse=0.
- o_ready rises the first cycle after rst is sampled low.
- Latency: a beat accepted at edge t appears on o_valid/o_data after edge t, i.e. 1 cycle, when the block was EMPTY or ONE with a simultaneous consume.
- Throughput: 1 beat/cycle sustained while i_ready=1.
- Backpressure: when i_ready=0 in ONE, at most one more beat is accepted (into SKID). o_ready is low from the next cycle.
- After i_ready returns high in FULL:
  - OUT is consumed that cycle.
  - SKID is presented the next cycle.
  - o_ready is high the next cycle.
- i_size may change every beat. Mixed sizes in consecutive beats are legal and have no bubble.

## Test plan
- Forward N=8, MAXN=32, lane k = k, i_ready=1 → one cycle later o lanes 0..7 = 0,2,4,6,1,3,5,7, lanes 8..31 = 8..31, o_size=01.
- Inverse N=32, lane k = k → o lanes = 0,16,1,17,…,15,31. Then forward-then-inverse random beats at each size (4/8/16/32) → output equals the original input.
- Sign: forward N=4, lanes = -1,5,-134217728,134217727 → o = -1,-134217728,5,134217727, bit-exact.
- Backpressure:
  - Stimulus: stream beats A,B,C,D with i_valid=1, hold i_ready=0 for 3 cycles after A appears.
  - Required: o_data=A held stable, B accepted into SKID, o_ready=0.
  - Required: C is not accepted until i_ready rises.
  - Required: the output sequence is A,B,C,D with no loss.
- Mixed sizes back-to-back (4, 32, 8, 16) with alternating i_inverse → each output matches its own size/mode, no bubbles.
- Reset mid-stream in state FULL: rst=1 for one cycle → next cycle o_valid=0, o_ready=0, o_data=0. Following cycle o_ready=1. Previously held beats never appear.
